// File: rtl/fop_pkg.sv
// Shared types and helpers for the FP operator responder: tag entries,
// width helpers and the fixed-priority pick used by the arbiter.
package fop_pkg;

    // Tags are stored at a fixed maximum width so one struct type serves every build.
    localparam int MAX_TAG_W    = 8;
    localparam int MAX_CLIENTS  = 1 << MAX_TAG_W;
    localparam int NCLIENTS_DEF = 4;
    localparam int LATENCY_DEF  = 4;

    function automatic int tag_width(input int nclients);
        return (nclients > 1) ? $clog2(nclients) : 1;
    endfunction

    function automatic int cnt_width(input int latency);
        return $clog2(latency + 2);
    endfunction

    localparam int TAG_W = tag_width(NCLIENTS_DEF);
    localparam int CNT_W = cnt_width(LATENCY_DEF);

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
    } tag_entry_t;

    function automatic logic [MAX_TAG_W-1:0] lowest_set_index(input logic [MAX_CLIENTS-1:0] v);
        logic [MAX_TAG_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CLIENTS - 1; i >= 0; i--) begin
            if (v[i]) idx = MAX_TAG_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fop_tag_pipe.sv
// Ownership pipeline: one tag entry per core pipeline slot plus the output
// slot, all advancing together with the core clock enable.
module fop_tag_pipe
    import fop_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  tag_entry_t         in_entry,
    output logic [LATENCY-1:0] stage_valid,
    output tag_entry_t         tail
);

    tag_entry_t [LATENCY:0] stage_q;
    tag_entry_t [LATENCY:0] stage_d;

    // Stage 0 can load unconditionally: it is only ever valid while en is high.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_entry;
        if (en) begin
            for (int k = 1; k <= LATENCY; k++) stage_d[k] = stage_q[k-1];
        end
    end

    // NOTE: the tag stages are reset even though they act as storage, because a
    // stale valid bit after reset would fire a response for a discarded request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_valid
        assign stage_valid[k] = stage_q[k].valid;
    end

    assign tail = stage_q[LATENCY];

endmodule

// File: rtl/fop_responder.sv
// Shares one fixed-latency pipelined FP core among NCLIENTS initiators:
// fixed-priority arbitration, registered core feed, tagged result return.
module fop_responder
    import fop_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NCLIENTS = 4,
    parameter int LATENCY  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCLIENTS*WIDTH-1:0]     req_x,
    input  logic [NCLIENTS*WIDTH-1:0]     req_y,
    input  logic [NCLIENTS-1:0]           req_ce,
    output logic [WIDTH-1:0]              core_x,
    output logic [WIDTH-1:0]              core_y,
    output logic                          core_ce,
    input  logic [WIDTH-1:0]              core_r,
    output logic [WIDTH-1:0]              resp_r,
    output logic [NCLIENTS-1:0]           resp_valid,
    output logic [$clog2(LATENCY+2)-1:0]  inflight,
    output logic [NCLIENTS-1:0]           collision_err
);

    localparam int OCC_W = cnt_width(LATENCY);

    if (NCLIENTS > MAX_CLIENTS) begin : g_too_many_clients
        $error("fop_responder: NCLIENTS exceeds the tag range");
    end

    logic [WIDTH-1:0]    core_x_q, core_x_d;
    logic [WIDTH-1:0]    core_y_q, core_y_d;
    logic                core_ce_q, core_ce_d;
    logic                last_adv_q, last_adv_d;
    logic [WIDTH-1:0]    resp_r_q, resp_r_d;
    logic [NCLIENTS-1:0] resp_valid_q, resp_valid_d;
    logic [NCLIENTS-1:0] collision_err_q, collision_err_d;
    logic [OCC_W-1:0]    inflight_q, inflight_d;

    logic                 grant_valid;
    logic [MAX_TAG_W-1:0] grant_idx;
    logic                 retire;
    tag_entry_t           in_entry;
    tag_entry_t           tail;
    logic [LATENCY-1:0]   stage_valid;

    fop_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (core_ce_q),
        .in_entry    (in_entry),
        .stage_valid (stage_valid),
        .tail        (tail)
    );

    // NOTE: every signal written here gets a default at the top of the block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_valid    = |req_ce;
        grant_idx      = lowest_set_index(MAX_CLIENTS'(req_ce));
        in_entry.valid = grant_valid;
        in_entry.tag   = grant_idx;

        // req_ce & (req_ce - 1) is every request except the lowest one.
        collision_err_d = collision_err_q | (req_ce & (req_ce - NCLIENTS'(1)));

        core_x_d = core_x_q;
        core_y_d = core_y_q;
        if (grant_valid) begin
            core_x_d = req_x[int'(grant_idx)*WIDTH +: WIDTH];
            core_y_d = req_y[int'(grant_idx)*WIDTH +: WIDTH];
        end

        // Occupancy of stages 0..LATENCY-1 as they will stand after this edge.
        inflight_d = OCC_W'(grant_valid);
        for (int k = 1; k < LATENCY; k++) begin
            inflight_d = inflight_d + OCC_W'(core_ce_q ? stage_valid[k-1] : stage_valid[k]);
        end
        core_ce_d = (inflight_d != '0);

        // The tail only counts once, on the edge right after it advanced into place;
        // after that the core has stalled and the tail merely holds.
        last_adv_d = core_ce_q;
        retire     = tail.valid & last_adv_q;

        resp_r_d = retire ? core_r : resp_r_q;
        for (int i = 0; i < NCLIENTS; i++) begin
            resp_valid_d[i] = retire && (tail.tag == MAX_TAG_W'(i));
        end
    end

    // NOTE: sequential state is written with <= only, so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_x_q        <= '0;
            core_y_q        <= '0;
            core_ce_q       <= 1'b0;
            last_adv_q      <= 1'b0;
            resp_r_q        <= '0;
            resp_valid_q    <= '0;
            collision_err_q <= '0;
            inflight_q      <= '0;
        end else begin
            core_x_q        <= core_x_d;
            core_y_q        <= core_y_d;
            core_ce_q       <= core_ce_d;
            last_adv_q      <= last_adv_d;
            resp_r_q        <= resp_r_d;
            resp_valid_q    <= resp_valid_d;
            collision_err_q <= collision_err_d;
            inflight_q      <= inflight_d;
        end
    end

    assign core_x        = core_x_q;
    assign core_y        = core_y_q;
    assign core_ce       = core_ce_q;
    assign resp_r        = resp_r_q;
    assign resp_valid    = resp_valid_q;
    assign collision_err = collision_err_q;
    assign inflight      = inflight_q;

endmodule

// File: tb/tb_fop_responder.sv
// Bench for fop_responder: a 4-client/LATENCY=4 build against a scheduled
// response model, plus a 1-client/LATENCY=1 build for streaming.
module tb_fop_responder;

    localparam int W     = 32;
    localparam int N     = 4;
    localparam int L     = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N*W-1:0] req_x, req_y;
    logic [N-1:0]   req_ce;
    logic [W-1:0]   core_x, core_y, core_r, resp_r;
    logic           core_ce;
    logic [N-1:0]   resp_valid, collision_err;
    logic [2:0]     inflight;

    logic [W-1:0] r1_x, r1_y, core1_x, core1_y, core1_r, resp1_r;
    logic         r1_ce, core1_ce, resp1_valid, coll1;
    logic [1:0]   inflight1;

    fop_responder #(.WIDTH(W), .NCLIENTS(N), .LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .req_x(req_x), .req_y(req_y), .req_ce(req_ce),
        .core_x(core_x), .core_y(core_y), .core_ce(core_ce), .core_r(core_r),
        .resp_r(resp_r), .resp_valid(resp_valid), .inflight(inflight),
        .collision_err(collision_err)
    );

    fop_responder #(.WIDTH(W), .NCLIENTS(1), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_x(r1_x), .req_y(r1_y), .req_ce(r1_ce),
        .core_x(core1_x), .core_y(core1_y), .core_ce(core1_ce), .core_r(core1_r),
        .resp_r(resp1_r), .resp_valid(resp1_valid), .inflight(inflight1),
        .collision_err(coll1)
    );

    // Single-precision multiply via double-precision reals (normal operands only).
    function automatic real sp2real(input logic [31:0] a);
        logic [10:0] e;
        logic [63:0] b;
        if (a[30:0] == 31'd0) return 0.0;
        e = 11'(a[30:23]) + 11'd896;
        b = {a[31], e, a[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        return real2sp(sp2real(a) * sp2real(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    // External cores: pipelines that advance only on ce.
    logic [W-1:0] core_pipe [L];
    always @(posedge clk) begin
        if (core_ce) begin
            core_pipe[0] <= fp_mul(core_x, core_y);
            for (int k = 1; k < L; k++) core_pipe[k] <= core_pipe[k-1];
        end
    end
    assign core_r = core_pipe[L-1];

    logic [W-1:0] core1_q;
    always @(posedge clk) if (core1_ce) core1_q <= fp_mul(core1_x, core1_y);
    assign core1_r = core1_q;

    // Reference model: responses scheduled by absolute edge number.
    logic [N-1:0] exp_rv  [DEPTH];
    logic [W-1:0] exp_rr  [DEPTH];
    bit           granted [DEPTH];
    logic [W-1:0] exp_cx, exp_cy, exp_resp_r;
    logic [N-1:0] exp_coll;
    int           edge_n;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            exp_rv[i]  = '0;
            exp_rr[i]  = '0;
            granted[i] = 1'b0;
        end
        exp_cx = '0; exp_cy = '0; exp_resp_r = '0; exp_coll = '0;
    endtask

    task automatic check_cycle();
        int e;
        int infl;
        e    = edge_n % DEPTH;
        infl = 0;
        for (int k = 0; k < L; k++) infl += int'(granted[(edge_n - k + DEPTH) % DEPTH]);
        if (exp_rv[e] != '0) exp_resp_r = exp_rr[e];
        check("resp_valid", 64'(resp_valid), 64'(exp_rv[e]));
        check("resp_r", 64'(resp_r), 64'(exp_resp_r));
        check("inflight", 64'(inflight), 64'(infl));
        check("core_ce", 64'(core_ce), 64'(infl != 0));
        check("core_x", 64'(core_x), 64'(exp_cx));
        check("core_y", 64'(core_y), 64'(exp_cy));
        check("collision_err", 64'(collision_err), 64'(exp_coll));
        exp_rv[e] = '0;
    endtask

    task automatic step(input logic [N-1:0] ce, input logic [N*W-1:0] xs, input logic [N*W-1:0] ys);
        int e;
        int g;
        @(negedge clk);
        req_ce = ce; req_x = xs; req_y = ys;
        e = edge_n + 1;
        g = -1;
        for (int i = N - 1; i >= 0; i--) if (ce[i]) g = i;
        granted[e % DEPTH] = (g >= 0);
        if (g >= 0) begin
            exp_cx = xs[g*W +: W];
            exp_cy = ys[g*W +: W];
            exp_rv[(e + L + 1) % DEPTH] = N'(1) << g;
            exp_rr[(e + L + 1) % DEPTH] = fp_mul(exp_cx, exp_cy);
            exp_coll = exp_coll | (ce & ~(N'(1) << g));
        end
        @(posedge clk);
        #1;
        edge_n = e;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, req_x, req_y);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_x"}, 64'(core_x), 64'd0);
        check({tag, "_core_y"}, 64'(core_y), 64'd0);
        check({tag, "_core_ce"}, 64'(core_ce), 64'd0);
        check({tag, "_resp_r"}, 64'(resp_r), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_inflight"}, 64'(inflight), 64'd0);
        check({tag, "_collision_err"}, 64'(collision_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N*W-1:0] xs, ys;
        logic [N-1:0]   ce;
        logic [W-1:0]   q1 [$];
        int             r;

        rst_n = 1'b0;
        req_ce = '0; req_x = '0; req_y = '0;
        r1_ce = 1'b0; r1_x = '0; r1_y = '0;
        edge_n = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_l1_valid", 64'(resp1_valid), 64'd0);
        check("reset_l1_core_ce", 64'(core1_ce), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from client 2: 2.0 * 3.0.
        xs = '0; ys = '0;
        xs[2*W +: W] = 32'h4000_0000;
        ys[2*W +: W] = 32'h4040_0000;
        step(4'b0100, xs, ys);
        idle(L + 1);
        check("single_valid", 64'(resp_valid), 64'h4);
        check("single_r", 64'(resp_r), 64'h40C0_0000);
        idle(4);

        // Back-to-back from clients 0, 1, 3.
        for (int l = 0; l < N; l++) begin xs[l*W +: W] = rand_fp(); ys[l*W +: W] = rand_fp(); end
        step(4'b0001, xs, ys);
        step(4'b0010, xs, ys);
        step(4'b1000, xs, ys);
        idle(L + 4);

        // Collision between clients 1 and 3.
        step(4'b1010, xs, ys);
        check("collision_first", 64'(collision_err), 64'h8);
        idle(L + 3);

        // Random traffic, including further collisions.
        for (int t = 0; t < 300; t++) begin
            for (int l = 0; l < N; l++) begin xs[l*W +: W] = rand_fp(); ys[l*W +: W] = rand_fp(); end
            r = $urandom_range(0, 9);
            if (r < 4)      ce = '0;
            else if (r < 8) ce = N'(1) << $urandom_range(0, N - 1);
            else            ce = N'($urandom);
            step(ce, xs, ys);
        end

        // Drain, then a long idle stretch: core_ce must stay low, operands held.
        idle(L + 3);
        idle(20);

        // Reset in the middle of traffic.
        step(4'b0001, xs, ys);
        step(4'b0010, xs, ys);
        step(4'b0100, xs, ys);
        #2;
        rst_n = 1'b0;
        req_ce = '0;
        #1;
        check_all_zero("async_reset");
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // LATENCY=1, NCLIENTS=1 build: eight consecutive requests.
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            r1_ce = (t < 8);
            r1_x  = rand_fp();
            r1_y  = rand_fp();
            if (t < 8) q1.push_back(fp_mul(r1_x, r1_y));
            @(posedge clk);
            #1;
            check("l1_valid", 64'(resp1_valid), 64'(t >= 2 && t <= 9));
            if (t >= 2 && t <= 9) check("l1_r", 64'(resp1_r), 64'(q1[t-2]));
            check("l1_inflight", 64'(inflight1), 64'(t < 8));
            check("l1_collision", 64'(coll1), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fop_responder.md
Name: fop_responder

Overview:
- Responder end of the operator interface (x, y, ce → r) that FP MAC controllers drive.
- Lets NCLIENTS initiators share one external fixed-latency pipelined FP core (FloPoCo-style fmul/fadd, pipeline advances only on ce).
- Arbitrates requests, feeds the core, tracks request ownership through a tag pipeline, and returns each result to its requester with a per-client valid strobe.

Parameters:
WIDTH, 32, operand/result width (precision)
NCLIENTS, 4, number of initiators (≥1)
LATENCY, 4, core pipeline depth in ce-enabled cycles (≥1)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset; asynchronous, active-low
req_x  in  NCLIENTS*WIDTH  client i operand x at [i*WIDTH +: WIDTH]
req_y  in  NCLIENTS*WIDTH  client i operand y, same packing
req_ce  in  NCLIENTS  client i issues a request this cycle
core_x  out  WIDTH  operand x to core (registered)
core_y  out  WIDTH  operand y to core (registered)
core_ce  out  1  core clock enable (registered)
core_r  in  WIDTH  core result
resp_r  out  WIDTH  result returned to clients (registered)
resp_valid  out  NCLIENTS  one-hot; bit i high for one cycle when resp_r belongs to client i
inflight  out  $clog2(LATENCY+2)  number of valid tag stages
collision_err  out  NCLIENTS  sticky; bit i set when client i's request was dropped

Behaviour:
- Reset (rst_n low, async): core_x=0, core_y=0, core_ce=0, resp_r=0, resp_valid=0, inflight=0, collision_err=0, all tag stages invalid.
- Arbitration: fixed priority, lowest index wins. grant = lowest set bit of req_ce.
- Every other set bit of req_ce in the same cycle sets its collision_err bit. That request is dropped: no core issue, no response. collision_err clears only on reset.
- Issue (edge where a grant exists):
  - core_x/core_y <= granted client's operands; core_ce <= 1.
  - Tag stage0 <= {valid=1, tag=grant index}.
- No grant: core_x/core_y hold their values. Stage0 <= invalid.
- core_ce <= 1 iff a grant exists or any tag stage 0..LATENCY-1 is valid after the edge (auto-drain). Otherwise core_ce <= 0, so the idle core sees ce=0.
- Tag pipeline: stages 0..LATENCY. Stage k+1 <= stage k on every edge where core_ce (registered value) is 1; otherwise all stages hold.
  - Pending work always keeps core_ce high, so the pipeline never stalls with entries in flight.
- Stage LATENCY aligns with valid core_r.
- Response: on each edge where stage LATENCY is valid and core_ce was 1:
  - resp_r <= core_r.
  - resp_valid <= onehot(tag).
  - Otherwise resp_valid <= 0 and resp_r holds.
- Latency: request sampled at edge E0 → resp_valid high during the cycle after edge E0+LATENCY+1. Fixed, independent of other traffic.
- Throughput: one issue per cycle. Back-to-back grants return back-to-back, in issue order.
- Simultaneous issue and retire: both happen on the same edge. inflight is net of both.
- inflight = count of valid stages 0..LATENCY-1, registered. Maximum value is LATENCY.
- Reset mid-operation: all in-flight results are discarded. No resp_valid follows reset deassertion until a new request completes.
- resp_valid is never multi-hot.

Decomposition:
- Package fop_pkg:
  - Localparams TAG_W = max(1, $clog2(NCLIENTS)) and CNT_W = $clog2(LATENCY+2).
  - typedef tag_entry_t {logic valid; logic [TAG_W-1:0] tag;}.
  - Function lowest_set_index.
- Sub-module fop_tag_pipe (LATENCY+1 stages of tag_entry_t with shared enable, async active-low reset). It is the natural split.
- Arbitration, core register stage, response stage and counters live in the top.

Test Plan:
- Single request: client 2 ce=1 for one cycle, x=0x40000000, y=0x40400000, core model returns x*y → resp_valid=4'b0100 exactly LATENCY+1 cycles later, resp_r=0x40C00000, inflight returns to 0, core_ce low afterward.
- Back-to-back: clients 0,1,3 issue on consecutive cycles → resp_valid=0001, 0010, 1000 on three consecutive cycles, each with the matching result.
- Collision: clients 1 and 3 ce in the same cycle → only client 1 answered; collision_err=4'b1000 and stays set through later traffic until reset.
- Reset mid-flight: issue 3 requests, drop rst_n after 2 cycles for 1 cycle → all outputs 0 immediately (async); no resp_valid for the next 10 cycles.
- Idle power: no requests for 20 cycles after drain → core_ce=0 throughout; core_x/core_y stable.
- LATENCY=1, NCLIENTS=1 build: continuous ce for 8 cycles → 8 consecutive resp_valid pulses starting 2 cycles after the first request; inflight never exceeds 1.
